micro8_system: RTL and testbench

//  Self-contained 8-bit microprocessor system: multi-cycle CPU core, 64 KB unified byte memory,

---
 rtl/micro8_pkg.sv | 16 +
 rtl/micro8_if.sv | 13 +
 rtl/micro8_core.sv | 88 ++++++++
 rtl/micro8_system.sv | 50 +++++
 tb/tb_micro8_system.sv | 127 ++++++++++++
 5 files changed

// File: rtl/micro8_pkg.sv
// micro8_pkg: opcodes, FSM states, reset vector and I/O port numbers for the micro8 system.
package micro8_pkg;
  localparam logic [15:0] RESET_VECTOR = 16'h8000;
  localparam int MEM_DEPTH = 65536;
  localparam logic [7:0] GPIO_PORT = 8'h80;
  localparam logic [7:0] UART_PORT = 8'h81;
  localparam logic [3:0] OP_NOP = 4'h0, OP_OUT = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4, OP_JMP = 4'h5, OP_LD = 4'h6, OP_ST = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_JZ = 4'hB;
  localparam logic [3:0] OP_JNZ = 4'hC, OP_HLT = 4'hF;
  typedef enum logic [2:0] {FETCH, OP1, OP2, EXEC, HALT} state_t;
  function automatic logic [1:0] operand_bytes(input logic [3:0] op);
    return op inside {OP_OUT, OP_LDI} ? 2'd1 :
           op inside {OP_JMP, OP_LD, OP_ST, OP_JZ, OP_JNZ} ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/micro8_if.sv
// micro8_if: core-to-system bus carrying memory accesses and OUT-port writes.
interface micro8_if;
  logic [15:0] addr;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic read;
  logic write;
  logic io_write;
  logic [7:0] io_port;
  logic [7:0] io_data;
  modport master(output addr, wdata, read, write, io_write, io_port, io_data, input rdata);
  modport slave(input addr, wdata, read, write, io_write, io_port, io_data, output rdata);
endinterface

// File: rtl/micro8_core.sv
// micro8_core: multi-cycle FETCH/OP1/OP2/EXEC CPU with four 8-bit registers and Z/C flags.
module micro8_core
  import micro8_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = micro8_pkg::RESET_VECTOR
) (
  input  logic clk,
  input  logic reset,
  micro8_if.master bus,
  output logic halt
);
  state_t state;
  logic [15:0] pc;
  logic [7:0] instruction, op1, op2, alu_result;
  logic [7:0] registers [0:3];
  logic z_flag, c_flag, alu_carry, cpu_en, writes_rd, take_jump;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] a, b;
  logic [15:0] target;
  assign op = instruction[7:4];
  assign rd = instruction[3:2];
  assign rs = instruction[1:0];
  assign a = registers[rd];
  assign b = registers[rs];
  assign target = {op2, op1};
  assign cpu_en = reset && state != HALT;
  assign halt = state == HALT;
  assign writes_rd = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_LD};
  assign take_jump = op == OP_JMP || (op == OP_JZ && z_flag) || (op == OP_JNZ && !z_flag);
  always_comb begin
    {alu_carry, alu_result} = op == OP_ADD ? {1'b0, a} + {1'b0, b} :
                              op == OP_SUB ? {a < b, a - b} :
                              op == OP_AND ? {1'b0, a & b} :
                              op == OP_OR  ? {1'b0, a | b} :
                              op == OP_XOR ? {1'b0, a ^ b} :
                              op == OP_LDI ? {c_flag, op1} :
                              op == OP_LD  ? {c_flag, bus.rdata} : {c_flag, 8'h00};
  end
  // LD/ST borrow the bus in EXEC; every other cycle it addresses pc
  assign bus.addr = (state == EXEC && op inside {OP_LD, OP_ST}) ? target : pc;
  assign bus.read = state inside {FETCH, OP1, OP2} || (state == EXEC && op == OP_LD);
  assign bus.write = cpu_en && state == EXEC && op == OP_ST;
  assign bus.wdata = a;
  assign bus.io_write = cpu_en && state == EXEC && op == OP_OUT;
  assign bus.io_port = op1;
  assign bus.io_data = a;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_VECTOR;
      instruction <= 8'h00;
      op1 <= 8'h00;
      op2 <= 8'h00;
      registers <= '{default: 8'h00};
      z_flag <= 1'b0;
      c_flag <= 1'b0;
    end else if (cpu_en) begin
      case (state)
        FETCH: begin
          instruction <= bus.rdata;
          pc <= pc + 16'd1;
          state <= operand_bytes(bus.rdata[7:4]) == 2'd0 ? EXEC : OP1;
        end
        OP1: begin
          op1 <= bus.rdata;
          pc <= pc + 16'd1;
          state <= operand_bytes(op) == 2'd2 ? OP2 : EXEC;
        end
        OP2: begin
          op2 <= bus.rdata;
          pc <= pc + 16'd1;
          state <= EXEC;
        end
        EXEC: begin
          if (writes_rd) begin
            registers[rd] <= alu_result;
            z_flag <= alu_result == 8'h00;
            c_flag <= alu_carry;
          end
          if (take_jump) pc <= target;
          state <= op == OP_HLT ? HALT : FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/micro8_system.sv
// micro8_system: micro8 CPU with 64 KB memory, GPIO latch and UART byte port.
// Define UART_TX_EN to enable the UART port; otherwise its outputs are tied low.
module micro8_system
  import micro8_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = micro8_pkg::RESET_VECTOR,
  parameter int MEM_DEPTH = micro8_pkg::MEM_DEPTH,
  parameter logic [7:0] GPIO_PORT = micro8_pkg::GPIO_PORT,
  parameter logic [7:0] UART_PORT = micro8_pkg::UART_PORT
) (
  input  logic clk,
  input  logic reset,
  output logic halt,
  output logic [7:0] gpio_out,
  output logic [7:0] uart_tx_data,
  output logic uart_tx_valid
);
  micro8_if bus();
  logic [15:0] mem_addr;
  logic [7:0] mem_data_out;
  logic mem_read, mem_write;
  logic [7:0] mem [0:MEM_DEPTH-1];
  micro8_core #(.RESET_VECTOR(RESET_VECTOR)) cpu (.clk(clk), .reset(reset), .bus(bus), .halt(halt));
  assign mem_addr = bus.addr;
  assign mem_read = bus.read;
  assign mem_write = bus.write;
  assign mem_data_out = mem_read ? mem[mem_addr] : 8'h00;
  assign bus.rdata = mem_data_out;
  always_ff @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= bus.wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset) gpio_out <= 8'h00;
    else if (bus.io_write && bus.io_port == GPIO_PORT) gpio_out <= bus.io_data;
  end
`ifdef UART_TX_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      uart_tx_data <= 8'h00;
      uart_tx_valid <= 1'b0;
    end else begin
      uart_tx_valid <= bus.io_write && bus.io_port == UART_PORT;
      if (bus.io_write && bus.io_port == UART_PORT) uart_tx_data <= bus.io_data;
    end
  end
`else
  assign uart_tx_data = 8'h00;
  assign uart_tx_valid = 1'b0;
`endif
endmodule

// File: tb/tb_micro8_system.sv
// tb_micro8_system: directed programs loaded at the reset vector, checked with immediate assertions.
module tb_micro8_system;
  import micro8_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt, uart_tx_valid;
  logic [7:0] gpio_out, uart_tx_data;
  int n_cmp = 0;
  int n_err = 0;
  int cycles;
  int pulses;
  logic [7:0] seen_data;
  logic [7:0] prog[$];
  micro8_if mon();
  micro8_system dut (.clk(clk), .reset(reset), .halt(halt), .gpio_out(gpio_out),
                     .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid));
  assign mon.addr = dut.mem_addr;
  assign mon.rdata = dut.mem_data_out;
  assign mon.read = dut.mem_read;
  assign mon.write = dut.mem_write;
  assign mon.wdata = dut.bus.wdata;
  assign mon.io_write = dut.bus.io_write;
  assign mon.io_port = dut.bus.io_port;
  assign mon.io_data = dut.bus.io_data;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start();
    reset = 1'b0;
    @(negedge clk);
    foreach (prog[i]) dut.mem[16'h8000 + 16'(i)] = prog[i];
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic run(output int n);
    n = 0;
    while (!halt && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", 32'(dut.cpu.pc), 32'h8000);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_uart_valid", 32'(uart_tx_valid), 32'h0);
    prog = '{8'h40, 8'h0A, 8'h44, 8'h05, 8'h21, 8'h10, 8'h80, 8'hF0};
    start();
    run(cycles);
    check("t1_cycles", 32'(cycles), 32'd13);
    check("t1_halt", 32'(halt), 32'h1);
    check("t1_gpio", 32'(gpio_out), 32'h0F);
    check("t1_r0", 32'(dut.cpu.registers[0]), 32'h0F);
    prog = '{8'h40, 8'hFF, 8'h44, 8'h01, 8'h21, 8'hB0, 8'h20, 8'h80};
    dut.mem[16'h8020] = 8'hF0;
    start();
    run(cycles);
    check("t2_cycles", 32'(cycles), 32'd14);
    check("t2_r0", 32'(dut.cpu.registers[0]), 32'h00);
    check("t2_z", 32'(dut.cpu.z_flag), 32'h1);
    check("t2_c", 32'(dut.cpu.c_flag), 32'h1);
    check("t2_pc", 32'(dut.cpu.pc), 32'h8021);
    prog = '{8'h48, 8'h5A, 8'h78, 8'h20, 8'h80, 8'h6C, 8'h20, 8'h80, 8'h1C, 8'h80, 8'hF0};
    start();
    run(cycles);
    check("t3_cycles", 32'(cycles), 32'd16);
    check("t3_mem", 32'(dut.mem[16'h8020]), 32'h5A);
    check("t3_r3", 32'(dut.cpu.registers[3]), 32'h5A);
    check("t3_gpio", 32'(gpio_out), 32'h5A);
    prog = '{8'h40, 8'h03, 8'h44, 8'h05, 8'h31, 8'hF0};
    start();
    run(cycles);
    check("sub_cycles", 32'(cycles), 32'd10);
    check("sub_r0", 32'(dut.cpu.registers[0]), 32'hFE);
    check("sub_c", 32'(dut.cpu.c_flag), 32'h1);
    check("sub_z", 32'(dut.cpu.z_flag), 32'h0);
    prog = '{8'h40, 8'h33, 8'h10, 8'h80, 8'h50, 8'h02, 8'h80};
    start();
    for (int i = 0; i < 11; i++) @(negedge clk);
    check("t4_gpio_before", 32'(gpio_out), 32'h33);
    check("t4_mid_state", 32'(dut.cpu.state), 32'(OP1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t4_pc", 32'(dut.cpu.pc), 32'h8000);
    check("t4_gpio", 32'(gpio_out), 32'h0);
    check("t4_halt", 32'(halt), 32'h0);
    check("t4_state", 32'(dut.cpu.state), 32'(FETCH));
    prog = '{8'h40, 8'h41, 8'h10, 8'h81, 8'hF0};
    start();
    pulses = 0;
    seen_data = 8'h00;
    cycles = 0;
    while (!halt && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (uart_tx_valid) begin
        pulses++;
        seen_data = uart_tx_data;
      end
    end
    check("t5_halt", 32'(halt), 32'h1);
    check("t5_gpio", 32'(gpio_out), 32'h0);
`ifdef UART_TX_EN
    check("t5_pulses", 32'(pulses), 32'd1);
    check("t5_data", 32'(seen_data), 32'h41);
`else
    check("t5_pulses", 32'(pulses), 32'd0);
    check("t5_data", 32'(uart_tx_data), 32'h00);
`endif
    prog = '{8'hD0, 8'hF0};
    start();
    run(cycles);
    check("t6_cycles", 32'(cycles), 32'd4);
    check("t6_halt", 32'(halt), 32'h1);
    check("t6_pc", 32'(dut.cpu.pc), 32'h8002);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
